if_fetch_unit: RTL and testbench

- Instruction-fetch stage; the producer feeding the IF/ID pipeline register.
- Owns the PC and issues requests to the instruction cache/memory over a req/ack handshake.
- Absorbs variable-latency cache misses, honours load-use stalls (`pc_write_i`) and branch redirects.
- Presents `fetch_pc_o`/`fetch_inst_o`/`fetch_valid_o` for IF/ID to latch at the next posedge. IF/ID inserts a 32'b0 bubble when valid is low.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/if_pc_reg.sv | 52 +++++
 rtl/if_fetch_unit.sv | 106 ++++++++++
 tb/tb_if_fetch_unit.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-stage types, constants and PC alignment helper
package cpu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INST   = 32'h0000_0000;
    localparam int          INST_BYTES = 4;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_pc_reg.sv
// rtl/if_pc_reg.sv - program counter with deferred-redirect capture
module if_pc_reg #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                INST_BYTES = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_target_i,
    input  logic              set_pending_i,
    input  logic              take_pending_i,
    input  logic              inc_i,
    input  logic [ADDR_W-1:0] target_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              redir_o
);

    logic [ADDR_W-1:0] r_pc_q;
    logic [ADDR_W-1:0] r_redir_pc_q;
    logic              r_redir_q;
    logic [ADDR_W-1:0] w_target;

    assign w_target = {target_i[ADDR_W-1:2], 2'b00};

    // An immediate redirect outranks a parked one; increment wraps modulo 2^ADDR_W.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc_q       <= RESET_PC;
            r_redir_pc_q <= RESET_PC;
            r_redir_q    <= 1'b0;
        end else begin
            if (load_target_i) begin
                r_pc_q <= w_target;
            end else if (take_pending_i) begin
                r_pc_q <= r_redir_pc_q;
            end else if (inc_i) begin
                r_pc_q <= r_pc_q + ADDR_W'(INST_BYTES);
            end

            if (set_pending_i) begin
                r_redir_q    <= 1'b1;
                r_redir_pc_q <= w_target;
            end else if (take_pending_i || load_target_i) begin
                r_redir_q <= 1'b0;
            end
        end
    end

    assign pc_o    = r_pc_q;
    assign redir_o = r_redir_q;

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage feeding the IF/ID register
module if_fetch_unit #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                INST_BYTES = cpu_pkg::INST_BYTES
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              pc_write_i,
    input  logic              branch_taken_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [31:0]       imem_data_i,
    output logic [ADDR_W-1:0] fetch_pc_o,
    output logic [31:0]       fetch_inst_o,
    output logic              fetch_valid_o,
    output logic              miss_stall_o
);

    import cpu_pkg::*;

    fetch_state_t      r_state_q;
    logic [31:0]       r_hold_q;
    logic [ADDR_W-1:0] w_pc;
    logic              w_redir;
    logic              w_in_req;
    logic              w_in_hold;
    logic              w_ack;
    logic              w_present;
    logic              w_load_target;
    logic              w_set_pending;
    logic              w_take_pending;
    logic              w_inc;
    logic              w_valid;

    assign w_in_req  = (r_state_q == S_REQ);
    assign w_in_hold = (r_state_q == S_HOLD);
    assign w_ack     = w_in_req & imem_ack_i;
    assign w_present = w_ack & ~w_redir;

    // A branch while a request is outstanding is parked until that request's ack.
    assign w_load_target  = branch_taken_i & (~w_in_req | imem_ack_i);
    assign w_set_pending  = branch_taken_i & w_in_req & ~imem_ack_i;
    assign w_take_pending = w_ack & w_redir;
    assign w_inc          = ~branch_taken_i & pc_write_i & (w_present | w_in_hold);

    if_pc_reg #(
        .ADDR_W     (ADDR_W),
        .RESET_PC   (RESET_PC),
        .INST_BYTES (INST_BYTES)
    ) u_pc_reg (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .load_target_i  (w_load_target),
        .set_pending_i  (w_set_pending),
        .take_pending_i (w_take_pending),
        .inc_i          (w_inc),
        .target_i       (branch_target_i),
        .pc_o           (w_pc),
        .redir_o        (w_redir)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q <= S_IDLE;
            r_hold_q  <= NOP_INST;
        end else begin
            case (r_state_q)
                S_IDLE: begin
                    if (start_i) begin
                        r_state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (imem_ack_i) begin
                        if (w_redir || branch_taken_i || pc_write_i) begin
                            r_state_q <= start_i ? S_REQ : S_IDLE;
                        end else begin
                            r_hold_q  <= imem_data_i;
                            r_state_q <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (branch_taken_i || pc_write_i) begin
                        r_hold_q  <= NOP_INST;
                        r_state_q <= start_i ? S_REQ : S_IDLE;
                    end
                end
                default: r_state_q <= S_IDLE;
            endcase
        end
    end

    assign w_valid       = w_present | w_in_hold;
    assign imem_req_o    = w_in_req;
    assign imem_addr_o   = w_in_req ? w_pc : '0;
    assign fetch_pc_o    = w_pc;
    assign fetch_valid_o = w_valid;
    assign fetch_inst_o  = w_in_hold ? r_hold_q : (w_present ? imem_data_i : NOP_INST);
    assign miss_stall_o  = start_i & ~w_valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - cycle-vector bench with presented-instruction scoreboard
module tb_if_fetch_unit;

    localparam logic [31:0] KEY  = 32'hA5A5_0000;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_i, start_i, pc_write_i, branch_taken_i, imem_ack_i;
    logic [31:0] branch_target_i, imem_data_i;
    logic        imem_req_o, fetch_valid_o, miss_stall_o;
    logic [31:0] imem_addr_o, fetch_pc_o, fetch_inst_o;

    typedef struct {
        logic        rst, start, pw, br, ack;
        logic [31:0] tgt;
        logic        chk, req;
        logic [31:0] pc;
        logic        val, miss;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .pc_write_i      (pc_write_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ack_i      (imem_ack_i),
        .imem_data_i     (imem_data_i),
        .fetch_pc_o      (fetch_pc_o),
        .fetch_inst_o    (fetch_inst_o),
        .fetch_valid_o   (fetch_valid_o),
        .miss_stall_o    (miss_stall_o)
    );

    task automatic add(input logic rst, st, pw, br, ack, input logic [31:0] tgt,
                       input logic chk, req, input logic [31:0] pc, input logic val, miss);
        vec_t v;
        v.rst = rst; v.start = st; v.pw = pw; v.br = br; v.ack = ack; v.tgt = tgt;
        v.chk = chk; v.req = req; v.pc = pc; v.val = val; v.miss = miss;
        vecs.push_back(v);
    endtask

    task automatic hit(input logic [31:0] pc);
        add(0, 1, 1, 0, 1, 32'h0, 1, 1, pc, 1, 0);
    endtask

    task automatic rst_row();
        add(1, 1, 1, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
    endtask

    task automatic idle_start();
        add(0, 1, 1, 0, 0, 32'h0, 1, 0, 32'h0, 0, 1);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp, input int idx);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s vec %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    vec_t v;
    exp_t e;

    initial begin
        rst_i = 1; start_i = 0; pc_write_i = 1; branch_taken_i = 0;
        branch_target_i = 0; imem_ack_i = 0; imem_data_i = JUNK;

        // back-to-back hits after reset
        add(0, 0, 1, 0, 0, 32'h0, 1, 0, 32'h0, 0, 0);
        idle_start();
        hit(0); hit(4); hit(8); hit(12);
        rst_row();
        // three-cycle miss at 8, then redirect during a miss at 16
        idle_start();
        hit(0); hit(4);
        repeat (3) add(0, 1, 1, 0, 0, 32'h0, 1, 1, 32'd8, 0, 1);
        hit(8); hit(12);
        add(0, 1, 1, 1, 0, 32'h103, 1, 1, 32'd16, 0, 1);
        add(0, 1, 1, 0, 0, 32'h0,   1, 1, 32'd16, 0, 1);
        add(0, 1, 1, 0, 1, 32'h0,   1, 1, 32'd16, 0, 1);
        hit(32'h100);
        // two redirects during one miss: the later target wins
        add(0, 1, 1, 1, 0, 32'h50, 1, 1, 32'h104, 0, 1);
        add(0, 1, 1, 1, 0, 32'h61, 1, 1, 32'h104, 0, 1);
        add(0, 1, 1, 0, 1, 32'h0,  1, 1, 32'h104, 0, 1);
        hit(32'h60);
        rst_row();
        // load-use stall on addr 4, then branch racing a stalled ack
        idle_start();
        hit(0);
        add(0, 1, 0, 0, 1, 32'h0, 1, 1, 32'd4, 1, 0);
        add(0, 1, 0, 0, 0, 32'h0, 1, 0, 32'd4, 1, 0);
        add(0, 1, 0, 0, 0, 32'h0, 1, 0, 32'd4, 1, 0);
        add(0, 1, 1, 0, 0, 32'h0, 1, 0, 32'd4, 1, 0);
        add(0, 1, 0, 1, 1, 32'h300, 1, 1, 32'd8, 1, 0);
        hit(32'h300);
        rst_row();
        // reset mid-miss, then PC wrap
        idle_start();
        hit(0); hit(4); hit(8); hit(12); hit(16);
        add(0, 1, 1, 0, 0, 32'h0, 1, 1, 32'd20, 0, 1);
        rst_row();
        add(0, 1, 1, 1, 0, 32'hFFFF_FFFF, 1, 0, 32'h0, 0, 1);
        hit(32'hFFFF_FFFC);
        hit(32'h0);
        // start falls with a request outstanding
        add(0, 0, 1, 0, 0, 32'h0, 1, 1, 32'd4, 0, 0);
        add(0, 0, 1, 0, 1, 32'h0, 1, 1, 32'd4, 1, 0);
        add(0, 0, 1, 0, 0, 32'h0, 1, 0, 32'd8, 0, 0);
        add(0, 0, 1, 0, 0, 32'h0, 1, 0, 32'd8, 0, 0);

        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            v = vecs[i];
            @(posedge clk);
            #1;
            rst_i           = v.rst;
            start_i         = v.start;
            pc_write_i      = v.pw;
            branch_taken_i  = v.br;
            branch_target_i = v.tgt;
            imem_ack_i      = v.ack;
            imem_data_i     = v.ack ? (imem_addr_o ^ KEY) : JUNK;
            if (v.chk && v.val) begin
                e.pc   = v.pc;
                e.inst = v.pc ^ KEY;
                sb.push_back(e);
            end
            @(negedge clk);
            if (v.chk) begin
                n_vec++;
                check("imem_req",   32'(imem_req_o),    32'(v.req),  i);
                check("fetch_valid", 32'(fetch_valid_o), 32'(v.val),  i);
                check("miss_stall", 32'(miss_stall_o),  32'(v.miss), i);
                check("fetch_pc",   fetch_pc_o,         v.pc,        i);
                if (v.req) check("imem_addr", imem_addr_o, v.pc, i);
                if (fetch_valid_o === 1'b1) begin
                    if (sb.size() == 0) begin
                        n_err++;
                        $display("FAIL sb_empty vec %0d: got valid with pc %h, want no instruction", i, fetch_pc_o);
                    end else begin
                        e = sb.pop_front();
                        check("sb_pc",   fetch_pc_o,   e.pc,   i);
                        check("sb_inst", fetch_inst_o, e.inst, i);
                    end
                end else if (!v.ack) begin
                    check("inst_bubble", fetch_inst_o, 32'h0, i);
                end
            end
        end

        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: got %0d unconsumed, want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
